// File: rtl/mac_pkg.sv
// Shared types and constants for the window MAC controller.
package mac_pkg;

  localparam int unsigned ROWS_DEF = 4;
  localparam int unsigned COLS_DEF = 4;
  localparam int unsigned IDX_W    = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StClear,
    StAcc,
    StDone
  } mac_state_e;

endpackage

// File: rtl/mac_index_counter.sv
// Row-major (i,j) window index counter with clear, hold and wrap.
module mac_index_counter
  import mac_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_hold,
  output logic [IDX_W-1:0] o_i,
  output logic [IDX_W-1:0] o_j,
  output logic             o_adv,
  output logic             o_wrap
);

  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] LAST_J = IDX_W'(COLS - 1);

  logic [IDX_W-1:0] r_i;
  logic [IDX_W-1:0] r_j;
  logic             w_row_end;
  logic             w_last;

  assign w_row_end = (r_j == LAST_J);
  assign w_last    = w_row_end && (r_i == LAST_I);
  assign o_adv     = i_en && !i_hold;
  assign o_wrap    = o_adv && w_last;
  assign o_i       = r_i;
  assign o_j       = r_j;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_clr) begin
      r_i <= '0;
      r_j <= '0;
    end else if (o_adv) begin
      if (w_row_end) begin
        r_j <= '0;
        // The final pair wraps both indices back to the origin.
        r_i <= w_last ? '0 : r_i + 1'b1;
      end else begin
        r_j <= r_j + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_controller.sv
// Window MAC sequencer: LOAD, CLEAR, ROWS*COLS ACC steps, then DONE captures the result.
// Define MAC_CTRL_HOLD_EN to add the hold input that stalls ACC.
module mac_controller
  import mac_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef MAC_CTRL_HOLD_EN
  input  logic             hold,
`endif
  input  logic [7:0]       res,
  output logic             ld_buf,
  output logic             register_rst,
  output logic             register_ld,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result
);

  mac_state_e r_state;
  logic [7:0] r_result;
  logic       w_hold;
  logic       w_adv;
  logic       w_wrap;

`ifdef MAC_CTRL_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  mac_index_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_idx (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (r_state == StClear),
    .i_en   (r_state == StAcc),
    .i_hold (w_hold),
    .o_i    (i),
    .o_j    (j),
    .o_adv  (w_adv),
    .o_wrap (w_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_result <= '0;
    end else begin
      unique case (r_state)
        StIdle:  if (start) r_state <= StLoad;
        StLoad:  r_state <= StClear;
        StClear: r_state <= StAcc;
        StAcc:   if (w_wrap) r_state <= StDone;
        StDone: begin
          r_result <= res;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Strobes are pure state decodes; only hold may gate the accumulator load.
  assign ld_buf       = (r_state == StLoad);
  assign register_rst = (r_state == StClear);
  assign register_ld  = w_adv;
  assign busy         = (r_state != StIdle);
  assign done         = (r_state == StDone);
  assign result       = r_result;

endmodule
